// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode constants, instruction format enum,
// decoded-instruction record and immediate helper.
package rv_pkg;

   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_ALI      = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_ALR      = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      TYPE_UNKNOWN = 3'd0,
      TYPE_R       = 3'd1,
      TYPE_I       = 3'd2,
      TYPE_S       = 3'd3,
      TYPE_B       = 3'd4,
      TYPE_U       = 3'd5,
      TYPE_J       = 3'd6
   } instr_type_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        rs1_en;
      logic        rs2_en;
      logic        rd_we;
      logic [31:0] imm;
      instr_type_e itype;
      logic        jal;
      logic        jalr;
      logic        branch;
      logic        mem2reg;
      logic        memwrite;
      logic        alures2reg;
      logic        illegal;
   } decoded_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: raw instruction word to decoded_t record,
// including illegal-instruction detection gated by the extension parameters.
module decode_comb
   import rv_pkg::*;
#(
   parameter bit ENABLE_M      = 1'b1,
   parameter bit ENABLE_SYSTEM = 1'b0
) (
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0]  opcode_s;
   logic [6:0]  func7_s;
   logic [2:0]  func3_s;
   logic [4:0]  rd_s;
   instr_type_e type_s;
   logic [31:0] imm_s;
   logic        alr_ok_s;
   logic        op_bad_s;
   logic        illegal_s;

   assign opcode_s = instr[6:0];
   assign func3_s  = instr[14:12];
   assign func7_s  = instr[31:25];
   assign rd_s     = instr[11:7];

   // Instruction format from the opcode
   always_comb begin
      case (opcode_s)
         OPCODE_ALR:                          type_s = TYPE_R;
         OPCODE_ALI, OPCODE_LOAD, OPCODE_JALR: type_s = TYPE_I;
         OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
            if (ENABLE_SYSTEM) type_s = TYPE_I;
            else               type_s = TYPE_UNKNOWN;
         end
         OPCODE_STORE:                        type_s = TYPE_S;
         OPCODE_BRANCH:                       type_s = TYPE_B;
         OPCODE_LUI, OPCODE_AUIPC:            type_s = TYPE_U;
         OPCODE_JAL:                          type_s = TYPE_J;
         default:                             type_s = TYPE_UNKNOWN;
      endcase
   end

   // Immediate reassembly per format
   always_comb begin
      case (type_s)
         TYPE_I:  imm_s = sext12(instr[31:20]);
         TYPE_S:  imm_s = sext12({instr[31:25], instr[11:7]});
         TYPE_B:  imm_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         TYPE_U:  imm_s = {instr[31:12], 12'h000};
         TYPE_J:  imm_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm_s = 32'h0000_0000;
      endcase
   end

   assign alr_ok_s = (func7_s == 7'b0000000)
                   || ((func7_s == 7'b0100000) && ((func3_s == 3'b000) || (func3_s == 3'b101)))
                   || ((func7_s == 7'b0000001) && ENABLE_M);

   // Opcode-specific encodings that are reserved
   always_comb begin
      case (opcode_s)
         OPCODE_ALR:    op_bad_s = !alr_ok_s;
         OPCODE_ALI:    op_bad_s = ((func3_s == 3'b001) && (func7_s != 7'b0000000))
                                || ((func3_s == 3'b101) && (func7_s != 7'b0000000)
                                                        && (func7_s != 7'b0100000));
         OPCODE_JALR:   op_bad_s = (func3_s != 3'b000);
         OPCODE_BRANCH: op_bad_s = (func3_s == 3'b010) || (func3_s == 3'b011);
         OPCODE_LOAD:   op_bad_s = (func3_s == 3'b011) || (func3_s == 3'b110) || (func3_s == 3'b111);
         OPCODE_STORE:  op_bad_s = (func3_s > 3'b010);
         default:       op_bad_s = 1'b0;
      endcase
   end

   assign illegal_s = (instr[1:0] != 2'b11) || (type_s == TYPE_UNKNOWN) || op_bad_s;

   // Assemble the record; illegal words carry raw fields but no side effects
   always_comb begin
      dec            = '0;
      dec.opcode     = opcode_s;
      dec.func3      = func3_s;
      dec.func7      = func7_s;
      dec.rs1_addr   = instr[19:15];
      dec.rs2_addr   = instr[24:20];
      dec.rd_addr    = rd_s;
      dec.imm        = imm_s;
      dec.itype      = type_s;
      dec.illegal    = illegal_s;
      dec.rs1_en     = !illegal_s && (type_s inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B});
      dec.rs2_en     = !illegal_s && (type_s inside {TYPE_R, TYPE_S, TYPE_B});
      dec.rd_we      = !illegal_s && (type_s inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J})
                                  && (rd_s != 5'd0);
      dec.jal        = !illegal_s && (opcode_s == OPCODE_JAL);
      dec.jalr       = !illegal_s && (opcode_s == OPCODE_JALR);
      dec.branch     = !illegal_s && (opcode_s == OPCODE_BRANCH);
      dec.mem2reg    = !illegal_s && (opcode_s == OPCODE_LOAD);
      dec.memwrite   = !illegal_s && (opcode_s == OPCODE_STORE);
      dec.alures2reg = !illegal_s && (opcode_s inside {OPCODE_JAL, OPCODE_JALR, OPCODE_LUI,
                                                       OPCODE_AUIPC, OPCODE_ALI, OPCODE_ALR});
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, one decoder, and a main output
// register backed by a skid register so throughput survives backpressure.
module decode_stage
   import rv_pkg::*;
#(
   parameter bit ENABLE_M      = 1'b1,
   parameter bit ENABLE_SYSTEM = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [6:0]  out_opcode,
   output logic [2:0]  out_func3,
   output logic [6:0]  out_func7,
   output logic [4:0]  out_rs1_addr,
   output logic [4:0]  out_rs2_addr,
   output logic [4:0]  out_rd_addr,
   output logic        out_rs1_en,
   output logic        out_rs2_en,
   output logic        out_rd_we,
   output logic [31:0] out_imm,
   output logic [2:0]  out_type,
   output logic        out_jal,
   output logic        out_jalr,
   output logic        out_branch,
   output logic        out_mem2reg,
   output logic        out_memwrite,
   output logic        out_alures2reg,
   output logic        out_illegal
);

   decoded_t    dec_s;
   decoded_t    main_r, main_nxt_s, skid_r, skid_nxt_s;
   logic [31:0] main_pc_r, main_pc_nxt_s, skid_pc_r, skid_pc_nxt_s;
   logic        out_valid_r, out_valid_nxt_s;
   logic        skid_valid_r, skid_valid_nxt_s;
   logic        in_ready_r;
   logic        accept_s;

   decode_comb #(
      .ENABLE_M      (ENABLE_M),
      .ENABLE_SYSTEM (ENABLE_SYSTEM)
   ) u_decode_comb (
      .instr (in_instr),
      .dec   (dec_s)
   );

   assign accept_s = in_valid && in_ready_r;

   // Buffer steering: main refills from skid first, else from the decoder
   always_comb begin
      main_nxt_s       = main_r;
      main_pc_nxt_s    = main_pc_r;
      skid_nxt_s       = skid_r;
      skid_pc_nxt_s    = skid_pc_r;
      out_valid_nxt_s  = out_valid_r;
      skid_valid_nxt_s = skid_valid_r;
      if (flush) begin
         out_valid_nxt_s  = 1'b0;
         skid_valid_nxt_s = 1'b0;
      end else if (!out_valid_r || out_ready) begin
         if (skid_valid_r) begin
            main_nxt_s       = skid_r;
            main_pc_nxt_s    = skid_pc_r;
            out_valid_nxt_s  = 1'b1;
            skid_valid_nxt_s = 1'b0;
         end else if (accept_s) begin
            main_nxt_s      = dec_s;
            main_pc_nxt_s   = in_pc;
            out_valid_nxt_s = 1'b1;
         end else begin
            out_valid_nxt_s = 1'b0;
         end
      end else if (accept_s) begin
         skid_nxt_s       = dec_s;
         skid_pc_nxt_s    = in_pc;
         skid_valid_nxt_s = 1'b1;
      end else begin
         skid_valid_nxt_s = skid_valid_r;
      end
   end

   // Buffer state and handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_r       <= '0;
         main_pc_r    <= 32'h0000_0000;
         skid_r       <= '0;
         skid_pc_r    <= 32'h0000_0000;
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         main_r       <= main_nxt_s;
         main_pc_r    <= main_pc_nxt_s;
         skid_r       <= skid_nxt_s;
         skid_pc_r    <= skid_pc_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         skid_valid_r <= skid_valid_nxt_s;
         in_ready_r   <= !skid_valid_nxt_s;
      end
   end

   assign in_ready       = in_ready_r;
   assign out_valid      = out_valid_r;
   assign out_pc         = main_pc_r;
   assign out_opcode     = main_r.opcode;
   assign out_func3      = main_r.func3;
   assign out_func7      = main_r.func7;
   assign out_rs1_addr   = main_r.rs1_addr;
   assign out_rs2_addr   = main_r.rs2_addr;
   assign out_rd_addr    = main_r.rd_addr;
   assign out_rs1_en     = main_r.rs1_en;
   assign out_rs2_en     = main_r.rs2_en;
   assign out_rd_we      = main_r.rd_we;
   assign out_imm        = main_r.imm;
   assign out_type       = main_r.itype;
   assign out_jal        = main_r.jal;
   assign out_jalr       = main_r.jalr;
   assign out_branch     = main_r.branch;
   assign out_mem2reg    = main_r.mem2reg;
   assign out_memwrite   = main_r.memwrite;
   assign out_alures2reg = main_r.alures2reg;
   assign out_illegal    = main_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random traffic against a queue-based
// occupancy model and an arithmetic reference decoder; two parameterisations.
module tb_decode_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_we;
   logic [31:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_func7;
   logic [2:0]  out_func3, out_type;
   logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
   logic        out_jal, out_jalr, out_branch, out_mem2reg, out_memwrite, out_alures2reg, out_illegal;

   logic        d2_in_ready, d2_out_valid, d2_rs1_en, d2_rs2_en, d2_rd_we;
   logic [31:0] d2_pc, d2_imm;
   logic [6:0]  d2_opcode, d2_func7;
   logic [2:0]  d2_func3, d2_type;
   logic [4:0]  d2_rs1_addr, d2_rs2_addr, d2_rd_addr;
   logic        d2_jal, d2_jalr, d2_branch, d2_mem2reg, d2_memwrite, d2_alures2reg, d2_illegal;

   decode_stage u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
      .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
      .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we), .out_imm(out_imm),
      .out_type(out_type), .out_jal(out_jal), .out_jalr(out_jalr), .out_branch(out_branch),
      .out_mem2reg(out_mem2reg), .out_memwrite(out_memwrite), .out_alures2reg(out_alures2reg),
      .out_illegal(out_illegal));

   decode_stage #(.ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(d2_out_valid), .out_ready(out_ready),
      .out_pc(d2_pc), .out_opcode(d2_opcode), .out_func3(d2_func3), .out_func7(d2_func7),
      .out_rs1_addr(d2_rs1_addr), .out_rs2_addr(d2_rs2_addr), .out_rd_addr(d2_rd_addr),
      .out_rs1_en(d2_rs1_en), .out_rs2_en(d2_rs2_en), .out_rd_we(d2_rd_we), .out_imm(d2_imm),
      .out_type(d2_type), .out_jal(d2_jal), .out_jalr(d2_jalr), .out_branch(d2_branch),
      .out_mem2reg(d2_mem2reg), .out_memwrite(d2_memwrite), .out_alures2reg(d2_alures2reg),
      .out_illegal(d2_illegal));

   logic [108:0] bus1, bus2;
   assign bus1 = {out_pc, out_opcode, out_func3, out_func7, out_rs1_addr, out_rs2_addr, out_rd_addr,
                  out_rs1_en, out_rs2_en, out_rd_we, out_imm, out_type, out_jal, out_jalr,
                  out_branch, out_mem2reg, out_memwrite, out_alures2reg, out_illegal};
   assign bus2 = {d2_pc, d2_opcode, d2_func3, d2_func7, d2_rs1_addr, d2_rs2_addr, d2_rd_addr,
                  d2_rs1_en, d2_rs2_en, d2_rd_we, d2_imm, d2_type, d2_jal, d2_jalr,
                  d2_branch, d2_mem2reg, d2_memwrite, d2_alures2reg, d2_illegal};

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] q[$];   // {instr, pc} of every instruction held in the stage

   // Reference decoder built from the ISA rules with integer arithmetic
   function automatic logic [108:0] ref_bus(input logic [31:0] ins, input logic [31:0] pc,
                                            input bit en_m, input bit en_sys);
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7; int t; int v; logic [31:0] imm;
      bit ill, r1, r2, we, alu;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      case (op)
         7'h33: t = 1;
         7'h13, 7'h03, 7'h67: t = 2;
         7'h0F, 7'h73: t = en_sys ? 2 : 0;
         7'h23: t = 3;
         7'h63: t = 4;
         7'h37, 7'h17: t = 5;
         7'h6F: t = 6;
         default: t = 0;
      endcase
      v = 0;
      if (t == 2) v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      if (t == 3) v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
      if (t == 4) v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                      - (ins[31] ? 4096 : 0);
      if (t == 6) v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                      - (ins[31] ? 1048576 : 0);
      imm = 32'(v);
      if (t == 5) imm = ins & 32'hFFFF_F000;
      ill = (ins[1:0] != 2'b11) || (t == 0);
      if (op == 7'h33 && !(f7 == 7'd0 || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'd1 && en_m)))
         ill = 1'b1;
      if (op == 7'h13 && ((f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32)))
         ill = 1'b1;
      if (op == 7'h67 && f3 != 3'd0) ill = 1'b1;
      if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) ill = 1'b1;
      if (op == 7'h03 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ill = 1'b1;
      if (op == 7'h23 && f3 > 3'd2) ill = 1'b1;
      r1  = !ill && (t >= 1 && t <= 4);
      r2  = !ill && (t == 1 || t == 3 || t == 4);
      we  = !ill && (t == 1 || t == 2 || t == 5 || t == 6) && (ins[11:7] != 5'd0);
      alu = !ill && (op == 7'h6F || op == 7'h67 || op == 7'h37 || op == 7'h17 || op == 7'h13 || op == 7'h33);
      return {pc, op, f3, f7, ins[19:15], ins[24:20], ins[11:7], r1, r2, we, imm, 3'(t),
              !ill && op == 7'h6F, !ill && op == 7'h67, !ill && op == 7'h63,
              !ill && op == 7'h03, !ill && op == 7'h23, alu, ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 13))
         0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h67;
         4: w[6:0] = 7'h0F;  5: w[6:0] = 7'h73;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h63;
         8: w[6:0] = 7'h37;  9: w[6:0] = 7'h17; 10: w[6:0] = 7'h6F;
        11: begin w[6:0] = 7'h33; w[31:25] = 7'd1; end
        12: begin w[6:0] = 7'h13; w[31:25] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32; end
         default: w = w;
      endcase
      return w;
   endfunction

   // Advance one clock, updating the occupancy model from pre-edge inputs
   task automatic step();
      bit rdy;
      rdy = (q.size() < 2);
      if (flush) q.delete();
      else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) q.push_back({in_instr, in_pc});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_vec++; if (bus1 !== 109'd0) begin n_err++; $display("FAIL reset_payload got %h want 0", bus1); end
      n_vec++; if (bus2 !== 109'd0) begin n_err++; $display("FAIL reset_payload2 got %h want 0", bus2); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
      step(); in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %0b want 1", out_valid); end
      n_vec++; if (out_imm !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
      n_vec++; if ({out_rs1_addr, out_rd_addr, out_rs1_en, out_rs2_en, out_rd_we, out_type} !== {5'd2, 5'd1, 3'b101, 3'd2})
         begin n_err++; $display("FAIL addi_fields got rs1=%0d rd=%0d en=%b%b%b type=%0d", out_rs1_addr, out_rd_addr, out_rs1_en, out_rs2_en, out_rd_we, out_type); end
      n_vec++; if (bus1 !== ref_bus(32'hFFF10093, 32'h100, 1'b1, 1'b0)) begin n_err++; $display("FAIL addi_bus got %h", bus1); end
      step();
   endtask

   task automatic test_branch();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h104;
      step(); in_valid = 1'b0;
      n_vec++; if ({out_valid, out_imm, out_branch, out_rd_we, out_type} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 3'd4})
         begin n_err++; $display("FAIL beq_fields got v=%0b imm=%h br=%0b we=%0b type=%0d want 1 fffffffc 1 0 4", out_valid, out_imm, out_branch, out_rd_we, out_type); end
      n_vec++; if (bus1 !== ref_bus(32'hFE000EE3, 32'h104, 1'b1, 1'b0)) begin n_err++; $display("FAIL beq_bus got %h", bus1); end
      step();
   endtask

   task automatic test_mul();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h020080B3; in_pc = 32'h108;
      step(); in_valid = 1'b0;
      n_vec++; if ({out_illegal, out_rd_we} !== 2'b01) begin n_err++; $display("FAIL mul_m_on got ill=%0b we=%0b want 0 1", out_illegal, out_rd_we); end
      n_vec++; if ({d2_illegal, d2_rs1_en, d2_rs2_en, d2_rd_we, d2_jal, d2_jalr, d2_branch, d2_mem2reg, d2_memwrite, d2_alures2reg} !== 10'b10_0000_0000)
         begin n_err++; $display("FAIL mul_m_off got ill=%0b flags=%b want 1 000000000", d2_illegal, {d2_rs1_en, d2_rs2_en, d2_rd_we, d2_jal, d2_jalr, d2_branch, d2_mem2reg, d2_memwrite, d2_alures2reg}); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] seen[$];
      bit acc;
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00500113; in_pc = 32'h200; step();
      in_instr = 32'h00208033; in_pc = 32'h204; step();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop got %0b want 0", in_ready); end
      in_instr = 32'h0000A183; in_pc = 32'h208;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         n_vec++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL b2b_valid cyc %0d got %0b want %0b", c, out_valid, q.size() > 0); end
         n_vec++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL b2b_ready cyc %0d got %0b want %0b", c, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            n_vec++; if (bus1 !== ref_bus(q[0][63:32], q[0][31:0], 1'b1, 1'b0)) begin n_err++; $display("FAIL b2b_bus cyc %0d got %h", c, bus1); end
         end
         if (out_valid && out_ready) seen.push_back(out_pc);
         acc = in_valid && (q.size() < 2);
         step();
         if (acc) in_valid = 1'b0;
      end
      n_vec++; if (seen.size() != 3 || seen[0] !== 32'h200 || seen[1] !== 32'h204 || seen[2] !== 32'h208)
         begin n_err++; $display("FAIL b2b_order got %0d items want 3 in order 200 204 208", seen.size()); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00100093; in_pc = 32'h300; step();
      in_instr = 32'h00200113; in_pc = 32'h304; step();
      flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h308; step();
      flush = 1'b0; in_valid = 1'b0;
      n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL flush_state got v=%0b r=%0b want 0 1", out_valid, in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak cyc %0d got pc %h", c, out_pc); end
         step();
      end
   endtask

   task automatic test_random(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         n_vec++; if (out_valid !== (q.size() > 0) || d2_out_valid !== (q.size() > 0))
            begin n_err++; $display("FAIL rnd_valid cyc %0d got %0b/%0b want %0b", c, out_valid, d2_out_valid, q.size() > 0); end
         n_vec++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", c, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            n_vec++; if (bus1 !== ref_bus(q[0][63:32], q[0][31:0], 1'b1, 1'b0))
               begin n_err++; $display("FAIL rnd_bus cyc %0d instr %h got %h", c, q[0][63:32], bus1); end
            n_vec++; if (bus2 !== ref_bus(q[0][63:32], q[0][31:0], 1'b0, 1'b1))
               begin n_err++; $display("FAIL rnd_bus2 cyc %0d instr %h got %h", c, q[0][63:32], bus2); end
         end
         step();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00A00513; in_pc = 32'h400; step();
      in_instr = 32'h00B00593; in_pc = 32'h404; step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL mrst_state got v=%0b r=%0b want 0 1", out_valid, in_ready); end
      n_vec++; if (bus1 !== 109'd0 || bus2 !== 109'd0) begin n_err++; $display("FAIL mrst_payload got %h want 0", bus1); end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00C00613; in_pc = 32'h500;
      step(); in_valid = 1'b0;
      n_vec++; if ({out_valid, out_pc} !== {1'b1, 32'h500}) begin n_err++; $display("FAIL mrst_resume got v=%0b pc=%h want 1 500", out_valid, out_pc); end
      n_vec++; if (bus1 !== ref_bus(32'h00C00613, 32'h500, 1'b1, 1'b0)) begin n_err++; $display("FAIL mrst_bus got %h", bus1); end
      step();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_mul();
      test_back_to_back();
      test_flush();
      test_random(600);
      test_mid_reset();
      test_random(200);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
